// File: rtl/predictor_branch_table.sv
// 2-bit saturating-counter branch table with an in-order in-flight FIFO.
// The FIFO head feeds the check stage; mispredicts clear it and emit a flush.
module predictor_branch_table #(
  parameter int ADDR_W  = 11,
  parameter int INDEX_W = 4,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic [1:0]        fetch_branch_type,
  input  logic [ADDR_W-1:0] fetch_target,
  output logic              pred_taken,
  output logic              fifo_full,
  output logic              chk_valid,
  output logic [ADDR_W-1:0] chk_branch_addr,
  output logic [ADDR_W-1:0] chk_jump_addr,
  output logic [1:0]        chk_branch_type,
  output logic              chk_branch_taken,
  input  logic              resolve_valid,
  input  logic              prediction_success,
  input  logic              branch_result,
  input  logic [ADDR_W-1:0] failback_addr,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_addr
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NCTR = 1 << INDEX_W;

  typedef struct packed {
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  jump;
    logic [1:0]         btype;
    logic               pred;
    logic [INDEX_W-1:0] idx;
  } entry_t;

  logic [1:0]        cnt_q [NCTR];
  logic [1:0]        cnt_d [NCTR];
  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] redirect_q, redirect_d;

  logic [INDEX_W-1:0] fetch_idx;
  logic               is_branch;
  logic               push;
  logic               pop;
  logic               mispredict;
  entry_t             head;
  entry_t             new_entry;

  assign fetch_idx  = fetch_pc[INDEX_W-1:0];
  assign is_branch  = fetch_branch_type != 2'b00;
  assign pred_taken = is_branch & cnt_q[fetch_idx][1];
  assign fifo_full  = count_q == CW'(DEPTH);
  assign chk_valid  = count_q != '0;
  assign head       = mem_q[rptr_q];

  assign pop        = resolve_valid & chk_valid;
  assign mispredict = pop & ~prediction_success;
  assign push       = fetch_valid & is_branch & ~fifo_full & ~mispredict;

  // Head fields are forced to zero when empty so reset clears them at once.
  assign chk_branch_addr  = chk_valid ? head.target : '0;
  assign chk_jump_addr    = chk_valid ? head.jump : '0;
  assign chk_branch_type  = chk_valid ? head.btype : '0;
  assign chk_branch_taken = chk_valid & head.pred;

  assign flush         = flush_q;
  assign redirect_addr = redirect_q;

  always_comb begin
    new_entry.target = fetch_target;
    new_entry.jump   = fetch_pc + ADDR_W'(1);
    new_entry.btype  = fetch_branch_type;
    new_entry.pred   = pred_taken;
    new_entry.idx    = fetch_idx;
  end

  always_comb begin
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    flush_d    = 1'b0;
    redirect_d = redirect_q;
    if (pop) begin
      if (branch_result && cnt_q[head.idx] != 2'b11)
        cnt_d[head.idx] = cnt_q[head.idx] + 2'd1;
      else if (!branch_result && cnt_q[head.idx] != 2'b00)
        cnt_d[head.idx] = cnt_q[head.idx] - 2'd1;
    end
    if (mispredict) begin
      flush_d    = 1'b1;
      redirect_d = failback_addr;
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = new_entry;
        wptr_d        = wptr_q + PW'(1);
      end
      if (pop)
        rptr_d = rptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCTR; i++)
        cnt_q[i] <= 2'b01;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
    end
  end

  // Entry storage needs no reset: nothing reads it while count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
